// File: rtl/line_refill_unit.sv
// line_refill_unit
//   Cache line refill engine: accepts a miss address, issues one AXI INCR
//   read burst for the whole line, assembles the R beats into a line
//   buffer and presents the filled line until the consumer takes it.
//
// Parameters
//   LINE_WIDTH      cache line width in bits
//   AXI_DATA_WIDTH  R-channel beat width in bits (BEATS = LINE_WIDTH/AXI_DATA_WIDTH)
//   ADDR_WIDTH      address width
//   ID_WIDTH        AXI ID width (ar_id_o is always 0)
//
// Ports
//   clk_i, rst_ni                      clock, async active-low reset
//   req_valid_i/req_ready_o/req_addr_i miss request
//   ar_*                               AXI read address channel (master side)
//   r_*                                AXI read data channel (master side)
//   line_valid_o/line_ready_i          filled line handshake
//   line_data_o/line_addr_o/line_err_o filled line, its aligned address, error
//   busy_o                             high whenever not idle
//
// Build option
//   LINE_REFILL_RESP_CHECK_EN  when defined, SLVERR/DECERR on any beat makes
//                              line_err_o sticky for that line.

module line_refill_unit #(
  parameter int LINE_WIDTH     = 256,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int ID_WIDTH       = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,

  input  logic                      req_valid_i,
  output logic                      req_ready_o,
  input  logic [ADDR_WIDTH-1:0]     req_addr_i,

  output logic                      ar_valid_o,
  input  logic                      ar_ready_i,
  output logic [ADDR_WIDTH-1:0]     ar_addr_o,
  output logic [7:0]                ar_len_o,
  output logic [2:0]                ar_size_o,
  output logic [1:0]                ar_burst_o,
  output logic [ID_WIDTH-1:0]       ar_id_o,

  input  logic                      r_valid_i,
  output logic                      r_ready_o,
  input  logic [AXI_DATA_WIDTH-1:0] r_data_i,
  input  logic [1:0]                r_resp_i,
  input  logic                      r_last_i,

  output logic                      line_valid_o,
  input  logic                      line_ready_i,
  output logic [LINE_WIDTH-1:0]     line_data_o,
  output logic [ADDR_WIDTH-1:0]     line_addr_o,
  output logic                      line_err_o,

  output logic                      busy_o
);

  localparam int BEATS = LINE_WIDTH / AXI_DATA_WIDTH;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0]      LAST_BEAT = CNT_W'(BEATS - 1);
  localparam logic [ADDR_WIDTH-1:0] OFS_MASK  = ADDR_WIDTH'(LINE_WIDTH / 8 - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_AR,
    S_RECV,
    S_DONE
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [LINE_WIDTH-1:0]   data_q;
  logic [CNT_W-1:0]        cnt_q;
  logic                    err_q;

  logic beat_fire;
  logic burst_end;

  assign beat_fire = r_valid_i && (state_q == S_RECV);
  // Burst ends on r_last or on the final line word, whichever is first;
  // the counter therefore never wraps inside a burst.
  assign burst_end = beat_fire && (r_last_i || (cnt_q == LAST_BEAT));

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (req_valid_i)  state_d = S_AR;
      S_AR:   if (ar_ready_i)   state_d = S_RECV;
      S_RECV: if (burst_end)    state_d = S_DONE;
      S_DONE: if (line_ready_i) state_d = S_IDLE;
      default:                  state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from the state register only
  always_comb begin
    req_ready_o  = 1'b0;
    ar_valid_o   = 1'b0;
    r_ready_o    = 1'b0;
    line_valid_o = 1'b0;
    busy_o       = 1'b1;
    case (state_q)
      S_IDLE: begin
        req_ready_o = 1'b1;
        busy_o      = 1'b0;
      end
      S_AR:    ar_valid_o   = 1'b1;
      S_RECV:  r_ready_o    = 1'b1;
      S_DONE:  line_valid_o = 1'b1;
      default: busy_o       = 1'b1;
    endcase
  end

  assign ar_addr_o   = addr_q;
  assign ar_len_o    = 8'(BEATS - 1);
  assign ar_size_o   = 3'($clog2(AXI_DATA_WIDTH / 8));
  assign ar_burst_o  = 2'b01;
  assign ar_id_o     = '0;
  assign line_data_o = data_q;
  assign line_addr_o = addr_q;
  assign line_err_o  = err_q && (state_q == S_DONE);

  // Line buffer, address, beat counter and error flag.
  // The buffer is cleared on accept so words skipped by an early r_last read 0.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q <= '0;
      data_q <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid_i) begin
            addr_q <= req_addr_i & ~OFS_MASK;
            data_q <= '0;
            cnt_q  <= '0;
            err_q  <= 1'b0;
          end
        end
        S_RECV: begin
          if (beat_fire) begin
            for (int unsigned k = 0; k < BEATS; k++) begin
              if (cnt_q == CNT_W'(k)) begin
                data_q[k*AXI_DATA_WIDTH +: AXI_DATA_WIDTH] <= r_data_i;
              end
            end
            if (!burst_end) begin
              cnt_q <= cnt_q + 1'b1;
            end
            if (r_last_i && (cnt_q != LAST_BEAT)) begin
              err_q <= 1'b1;
            end
`ifdef LINE_REFILL_RESP_CHECK_EN
            if (r_resp_i[1]) begin
              err_q <= 1'b1;
            end
`endif
          end
        end
        default: ;
      endcase
    end
  end

`ifdef LINE_REFILL_RESP_CHECK_EN
  logic unused_resp;
  assign unused_resp = r_resp_i[0];
`else
  logic unused_resp;
  assign unused_resp = ^r_resp_i;
`endif

endmodule

// File: tb/tb_line_refill_unit.sv
module tb_line_refill_unit;

`ifdef LINE_REFILL_RESP_CHECK_EN
  localparam bit RESP_EN = 1'b1;
`else
  localparam bit RESP_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_ni;
  logic         req_valid;
  logic         req_ready_o;
  logic [31:0]  req_addr;
  logic         ar_valid_o;
  logic         ar_ready;
  logic [31:0]  ar_addr_o;
  logic [7:0]   ar_len_o;
  logic [2:0]   ar_size_o;
  logic [1:0]   ar_burst_o;
  logic [3:0]   ar_id_o;
  logic         r_valid;
  logic         r_ready_o;
  logic [31:0]  r_data;
  logic [1:0]   r_resp;
  logic         r_last;
  logic         line_valid_o;
  logic         line_ready;
  logic [255:0] line_data_o;
  logic [31:0]  line_addr_o;
  logic         line_err_o;
  logic         busy_o;

  always #5 clk = ~clk;

  line_refill_unit #(
    .LINE_WIDTH    (256),
    .AXI_DATA_WIDTH(32),
    .ADDR_WIDTH    (32),
    .ID_WIDTH      (4)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready_o),
    .req_addr_i  (req_addr),
    .ar_valid_o  (ar_valid_o),
    .ar_ready_i  (ar_ready),
    .ar_addr_o   (ar_addr_o),
    .ar_len_o    (ar_len_o),
    .ar_size_o   (ar_size_o),
    .ar_burst_o  (ar_burst_o),
    .ar_id_o     (ar_id_o),
    .r_valid_i   (r_valid),
    .r_ready_o   (r_ready_o),
    .r_data_i    (r_data),
    .r_resp_i    (r_resp),
    .r_last_i    (r_last),
    .line_valid_o(line_valid_o),
    .line_ready_i(line_ready),
    .line_data_o (line_data_o),
    .line_addr_o (line_addr_o),
    .line_err_o  (line_err_o),
    .busy_o      (busy_o)
  );

  typedef struct packed {
    logic [31:0]  addr;
    logic [255:0] data;
    logic         err;
  } line_t;

  line_t       sb[$];
  int          errors = 0;
  int          checks = 0;
  int          cyc    = 0;
  logic [31:0] bv [8];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_beats(input logic [31:0] base, input logic [31:0] step);
    for (int k = 0; k < 8; k++) bv[k] = base + step * k;
  endtask

  // Monitor: every line handshake is compared against the oldest expected line.
  always @(negedge clk) begin
    line_t e;
    if (rst_ni && line_valid_o && line_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL mon_unexpected: got line addr %h expected no line", line_addr_o);
      end else begin
        e = sb.pop_front();
        chk("mon_data", line_data_o, e.data);
        chk("mon_addr", 256'(line_addr_o), 256'(e.addr));
        chk("mon_err",  256'(line_err_o),  256'(e.err));
      end
    end
  end

  // One full refill. Called and returns at posedge+1 with the DUT idle.
  task automatic transact(input string tag, input logic [31:0] addr, input logic [31:0] exp_addr,
                          input int nbeats, input int stall, input bit toggle, input int resp_beat,
                          input int ready_wait, input logic [255:0] exp_line, input bit exp_err,
                          input bit check_lat);
    int    a_cyc;
    int    k;
    int    guard;
    bit    ph;
    bit    rdy;
    line_t e;
    chk({tag, "_req_ready_idle"}, 256'(req_ready_o), 256'(1));
    e.addr = exp_addr; e.data = exp_line; e.err = exp_err;
    sb.push_back(e);
    req_valid = 1'b1;
    req_addr  = addr;
    ar_ready  = (stall == 0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    a_cyc     = cyc;
    chk({tag, "_ar_valid"}, 256'(ar_valid_o), 256'(1));
    chk({tag, "_ar_addr"},  256'(ar_addr_o),  256'(exp_addr));
    chk({tag, "_ar_len"},   256'(ar_len_o),   256'(7));
    chk({tag, "_ar_size"},  256'(ar_size_o),  256'(2));
    chk({tag, "_ar_burst"}, 256'(ar_burst_o), 256'(1));
    chk({tag, "_ar_id"},    256'(ar_id_o),    256'(0));
    chk({tag, "_busy_ar"},  256'(busy_o),     256'(1));
    chk({tag, "_req_ready_ar"}, 256'(req_ready_o), 256'(0));
    for (int i = 0; i < stall; i++) begin
      chk({tag, "_stall_ar_valid"}, 256'(ar_valid_o), 256'(1));
      chk({tag, "_stall_ar_addr"},  256'(ar_addr_o),  256'(exp_addr));
      chk({tag, "_stall_r_ready"},  256'(r_ready_o),  256'(0));
      @(posedge clk); #1;
    end
    ar_ready = 1'b1;
    @(posedge clk); #1;
    ar_ready = 1'b0;
    k = 0; ph = 1'b0; guard = 0;
    while (k < nbeats && guard < 40) begin
      r_valid = !(toggle && ph);
      r_data  = bv[k];
      r_last  = (k == nbeats - 1);
      r_resp  = (k == resp_beat) ? 2'b10 : 2'b00;
      rdy     = r_ready_o;
      chk({tag, "_r_ready_recv"}, 256'(rdy), 256'(1));
      @(posedge clk); #1;
      if (r_valid && rdy) k++;
      ph = !ph;
      guard++;
    end
    if (k < nbeats) chk({tag, "_beats_timeout"}, 256'(k), 256'(nbeats));
    r_valid = 1'b0; r_last = 1'b0; r_resp = 2'b00;
    guard = 0;
    while (!line_valid_o && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    chk({tag, "_line_valid"}, 256'(line_valid_o), 256'(1));
    // Counted from the accept cycle as cycle 0: DONE is visible in cycle 2+BEATS.
    if (check_lat) chk({tag, "_latency"}, 256'(cyc - a_cyc + 1), 256'(10));
    r_valid = 1'b1;
    r_data  = 32'hBAD0BAD0;
    for (int i = 0; i < ready_wait; i++) begin
      chk({tag, "_hold_valid"},     256'(line_valid_o), 256'(1));
      chk({tag, "_hold_data"},      line_data_o,        exp_line);
      chk({tag, "_hold_addr"},      256'(line_addr_o),  256'(exp_addr));
      chk({tag, "_hold_err"},       256'(line_err_o),   256'(exp_err));
      chk({tag, "_hold_req_ready"}, 256'(req_ready_o),  256'(0));
      chk({tag, "_hold_r_ready"},   256'(r_ready_o),    256'(0));
      @(posedge clk); #1;
    end
    r_valid    = 1'b0;
    line_ready = 1'b1;
    @(posedge clk); #1;
    line_ready = 1'b0;
    chk({tag, "_after_valid"},     256'(line_valid_o), 256'(0));
    chk({tag, "_after_req_ready"}, 256'(req_ready_o),  256'(1));
    chk({tag, "_after_busy"},      256'(busy_o),       256'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_ni = 1'b0; req_valid = 1'b0; req_addr = '0; ar_ready = 1'b0;
    r_valid = 1'b0; r_data = '0; r_resp = 2'b00; r_last = 1'b0; line_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ar_valid",   256'(ar_valid_o),   256'(0));
    chk("rst_r_ready",    256'(r_ready_o),    256'(0));
    chk("rst_line_valid", 256'(line_valid_o), 256'(0));
    chk("rst_line_err",   256'(line_err_o),   256'(0));
    chk("rst_busy",       256'(busy_o),       256'(0));
    chk("rst_line_data",  line_data_o,        256'(0));
    chk("rst_line_addr",  256'(line_addr_o),  256'(0));
    rst_ni = 1'b1;
    @(posedge clk); #1;
    chk("rst_req_ready",  256'(req_ready_o),  256'(1));

    // Basic refill with latency
    set_beats(32'h11111111, 32'h11111111);
    transact("t1", 32'h8000_1234, 32'h8000_1220, 8, 0, 1'b0, -1, 1,
             256'h88888888_77777777_66666666_55555555_44444444_33333333_22222222_11111111,
             1'b0, 1'b1);

    // AR stalled five cycles
    set_beats(32'hC0DE0000, 32'h1);
    transact("t2", 32'h0000_00FF, 32'h0000_00E0, 8, 5, 1'b0, -1, 1,
             256'hC0DE0007_C0DE0006_C0DE0005_C0DE0004_C0DE0003_C0DE0002_C0DE0001_C0DE0000,
             1'b0, 1'b0);

    // Bubbled R channel, consumer back-pressure for three cycles
    set_beats(32'hDEAD0000, 32'h10);
    transact("t3", 32'h1234_5678, 32'h1234_5660, 8, 0, 1'b1, -1, 3,
             256'hDEAD0070_DEAD0060_DEAD0050_DEAD0040_DEAD0030_DEAD0020_DEAD0010_DEAD0000,
             1'b0, 1'b0);

    // Early r_last on beat 4: upper half zero, error flagged
    set_beats(32'hAAAA0000, 32'h1);
    transact("t4", 32'h0000_0040, 32'h0000_0040, 4, 0, 1'b0, -1, 2,
             256'h00000000_00000000_00000000_00000000_AAAA0003_AAAA0002_AAAA0001_AAAA0000,
             1'b1, 1'b0);

    // SLVERR on beat 3: full burst still drained, error only with response checking
    set_beats(32'h5A5A0000, 32'h1);
    transact("t5", 32'hFFFF_FFFF, 32'hFFFF_FFE0, 8, 0, 1'b0, 2, 1,
             256'h5A5A0007_5A5A0006_5A5A0005_5A5A0004_5A5A0003_5A5A0002_5A5A0001_5A5A0000,
             RESP_EN, 1'b0);

    // Reset on beat 5 abandons the burst
    set_beats(32'h77770000, 32'h1);
    req_valid = 1'b1; req_addr = 32'h2000_0000; ar_ready = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    ar_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      r_valid = 1'b1; r_data = bv[k];
      @(posedge clk); #1;
    end
    r_data = bv[4];
    rst_ni = 1'b0;
    #1;
    chk("abort_ar_valid",   256'(ar_valid_o),   256'(0));
    chk("abort_r_ready",    256'(r_ready_o),    256'(0));
    chk("abort_line_valid", 256'(line_valid_o), 256'(0));
    chk("abort_line_err",   256'(line_err_o),   256'(0));
    chk("abort_busy",       256'(busy_o),       256'(0));
    chk("abort_line_data",  line_data_o,        256'(0));
    chk("abort_line_addr",  256'(line_addr_o),  256'(0));
    @(posedge clk); #1;
    rst_ni  = 1'b1;
    r_valid = 1'b0;
    @(posedge clk); #1;
    chk("abort_req_ready", 256'(req_ready_o), 256'(1));

    set_beats(32'h11111111, 32'h11111111);
    transact("t6", 32'h8000_1234, 32'h8000_1220, 8, 0, 1'b0, -1, 1,
             256'h88888888_77777777_66666666_55555555_44444444_33333333_22222222_11111111,
             1'b0, 1'b1);

    repeat (2) @(posedge clk);
    #1;
    chk("sb_drained", 256'(sb.size()), 256'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
